// File: rtl/alu_issue_ctrl.sv
// Two-requester issue controller for the shared ALU: round-robin grant,
// registered operands, one execute cycle, and a response held until accepted.
module alu_issue_ctrl #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_carry,
  input  logic         rsp_ready
);

  localparam int SH_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           last;
  logic           grant0, grant1;
  logic [2:0]     op_p0;
  logic [W-1:0]   a_p0, b_p0;
  logic           id_p0;
  logic [W:0]     exec_out;
  logic [W-1:0]   exec_res;
  logic           exec_cy;

  // Returns {carry, result} for one operation on unsigned W-bit operands.
  function automatic logic [W:0] alu_eval(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]          sum;
    logic signed [W-1:0] sa, sb;
    logic [W-1:0]        res;
    logic                cy;
    sum = {1'b0, a} + {1'b0, b};
    sa  = a;
    sb  = b;
    res = '0;
    cy  = 1'b0;
    case (op)
      3'b000: begin res = sum[W-1:0]; cy = sum[W]; end
      3'b001: begin res = a - b;      cy = (a >= b); end
      3'b010: res = a & b;
      3'b011: res = a | b;
      3'b100: res = a ^ b;
      3'b101: res = {{(W-1){1'b0}}, (sa < sb)};
      3'b110: res = a << b[SH_W-1:0];
      3'b111: res = a >> b[SH_W-1:0];
      default: res = '0;
    endcase
    return {cy, res};
  endfunction

  // A lone valid requester wins; on a tie the one not served last wins.
  assign grant0 = req0_valid & (~req1_valid | last);
  assign grant1 = req1_valid & (~req0_valid | ~last);

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign rsp_valid  = (state == RESP);

  assign exec_out = alu_eval(op_p0, a_p0, b_p0);
  assign exec_res = exec_out[W-1:0];
  assign exec_cy  = exec_out[W];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 | grant1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (req0_ready)      last <= 1'b0;
      else if (req1_ready) last <= 1'b1;
    end
  end

  // Stage p0: operands captured on the accept edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_p0 <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
      id_p0 <= 1'b0;
    end else if (req0_ready) begin
      op_p0 <= req0_op;
      a_p0  <= req0_a;
      b_p0  <= req0_b;
      id_p0 <= 1'b0;
    end else if (req1_ready) begin
      op_p0 <= req1_op;
      a_p0  <= req1_a;
      b_p0  <= req1_b;
      id_p0 <= 1'b1;
    end
  end

  // Response stage: result and flags loaded leaving EXEC, held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id     <= id_p0;
      rsp_result <= exec_res;
      rsp_zero   <= (exec_res == '0);
      rsp_carry  <= exec_cy;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: expected responses are queued at the
// accept point and compared when the response handshake occurs.
module tb_alu_issue_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_ready;
  logic [W-1:0] rsp_result;

  int checks = 0;
  int errors = 0;
  logic [33:0] sb[$];
  logic [33:0] mon_e;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_ready(rsp_ready)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: {carry, result}.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {(a >= b), a - b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return (sa < sbv) ? 33'd1 : 33'd0;
      3'd6: return {1'b0, a << b[4:0]};
      default: return {1'b0, a >> b[4:0]};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk_eq("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk_eq("rsp_id", 64'(rsp_id), 64'(mon_e[33]));
        chk_eq("rsp_carry", 64'(rsp_carry), 64'(mon_e[32]));
        chk_eq("rsp_result", 64'(rsp_result), 64'(mon_e[31:0]));
        chk_eq("rsp_zero", 64'(rsp_zero), 64'(mon_e[31:0] == 32'd0));
      end
    end
  end

  task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [32:0] exp);
    int n = 0;
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? req1_ready : req0_ready) && n < 50);
    if (id ? req1_ready : req0_ready) sb.push_back({id, exp});
    else chk_eq("grant_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] sw_res [0:7] = '{32'h80000006, 32'h80000002, 32'h00000000, 32'h80000006,
                                32'h80000006, 32'h00000001, 32'h00000010, 32'h20000001};
  logic [7:0]  sw_cy = 8'b0000_0010;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk_eq("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk_eq("rst_flags", 64'({rsp_zero, rsp_carry}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("idle_no_ready", 64'({req1_ready, req0_ready}), 64'd0);
    @(posedge clk); #1;

    // Single request with latency checks
    rsp_ready = 1'b1;
    req0_op = 3'd0; req0_a = 32'hFFFFFFFF; req0_b = 32'd1; req0_valid = 1'b1;
    @(negedge clk);
    chk_eq("first_ready", 64'({req1_ready, req0_ready}), 64'd1);
    sb.push_back({1'b0, 1'b1, 32'd0});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk_eq("exec_no_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk_eq("rsp_at_t1", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    chk_eq("idle_after_t2", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;

    // Opcode sweep
    for (int i = 0; i < 8; i++)
      issue(1'b0, 3'(i), 32'h80000004, 32'h00000002, {sw_cy[i], sw_res[i]});
    wait_drain();

    // Serve requester 1 so requester 0 wins the next tie
    issue(1'b1, 3'd4, 32'd5, 32'd3, model(3'd4, 32'd5, 32'd3));
    wait_drain();

    // Round-robin with both requesters continuously valid
    req0_op = 3'd0; req0_a = 32'd10; req0_b = 32'd1;
    req1_op = 3'd1; req1_a = 32'd10; req1_b = 32'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(req0_ready || req1_ready) && n < 50);
      chk_eq("rr_grant", 64'({req1_ready, req0_ready}), (k % 2) ? 64'd2 : 64'd1);
      if (req1_ready)      sb.push_back({1'b1, model(req1_op, req1_a, req1_b)});
      else if (req0_ready) sb.push_back({1'b0, model(req0_op, req0_a, req0_b)});
      @(posedge clk); #1;
      req0_a = req0_a + 32'd7;
      req1_b = req1_b + 32'd13;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    // Response back-pressure with requester 1 waiting
    rsp_ready = 1'b0;
    issue(1'b0, 3'd0, 32'h12345678, 32'h11111111, {1'b0, 32'h23456789});
    req1_op = 3'd3; req1_a = 32'hF0; req1_b = 32'h0F; req1_valid = 1'b1;
    @(negedge clk);
    chk_eq("bp_exec_ready1", 64'(req1_ready), 64'd0);
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      chk_eq("bp_valid", 64'(rsp_valid), 64'd1);
      chk_eq("bp_result", 64'(rsp_result), 64'h23456789);
      chk_eq("bp_id", 64'(rsp_id), 64'd0);
      chk_eq("bp_ready1", 64'(req1_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk_eq("hs_cycle_ready1", 64'(req1_ready), 64'd0);
    @(negedge clk);
    chk_eq("post_hs_ready1", 64'(req1_ready), 64'd1);
    sb.push_back({1'b1, 1'b0, 32'hFF});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_drain();

    // Reset during EXEC discards the operation
    req1_op = 3'd1; req1_a = 32'd9; req1_b = 32'd4; req1_valid = 1'b1;
    @(negedge clk);
    chk_eq("mid_rst_grant", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk_eq("mid_rst_result", 64'(rsp_result), 64'd0);
    chk_eq("mid_rst_id", 64'(rsp_id), 64'd0);
    chk_eq("mid_rst_flags", 64'({rsp_zero, rsp_carry}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_eq("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    req0_op = 3'd2; req0_a = 32'hF; req0_b = 32'h3; req0_valid = 1'b1;
    req1_op = 3'd0; req1_a = 32'd1; req1_b = 32'd1; req1_valid = 1'b1;
    @(negedge clk);
    chk_eq("post_rst_tie", 64'({req1_ready, req0_ready}), 64'd1);
    sb.push_back({1'b0, 1'b0, 32'h3});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    // Operand change after accept has no effect
    issue(1'b0, 3'd0, 32'd3, 32'd4, {1'b0, 32'd7});
    req0_a = 32'd100;
    wait_drain();

    // Random mix
    for (int r = 0; r < 16; r++) begin
      logic        id;
      logic [2:0]  op;
      logic [31:0] a, b;
      id = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (r % 4 == 0) ? a : $urandom;
      issue(id, op, a, b, model(op, a, b));
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencer and arbiter for the shared ALU datapath and its W-bit operand and result registers. Two requesters each present an operation with a valid/ready handshake. A round-robin arbiter grants one requester, which owns the datapath. The block registers the operands, executes, registers the result and flags, and holds the response until the consumer accepts it. It sits between the instruction-issue logic and the ALU register bank.

## Interface
- W, 32, datapath width (power of two, ≥ 8)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_op  in  3  requester 0 opcode
- req0_a  in  W  requester 0 operand A
- req0_b  in  W  requester 0 operand B
- req0_ready  out  1  requester 0 accepted this cycle if valid
- req1_valid, req1_op, req1_a, req1_b, req1_ready: same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_id  out  1  requester that owns the response
- rsp_result  out  W  registered result
- rsp_zero  out  1  rsp_result == 0
- rsp_carry  out  1  carry / no-borrow flag
- rsp_ready  in  1  consumer accepts response

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE, arbitration:
  - Grant goes to the single valid requester.
  - If both are valid, grant the one not served last (pointer `last`).
  - reqN_ready = (state==IDLE) & grantN, combinational. At most one ready is high.
  - Never assert ready outside IDLE.
- Accept edge (reqN_valid & reqN_ready):
  - Operand registers ← a, b.
  - op register ← op.
  - id ← N.
  - last ← N.
  - state → EXEC.
- EXEC: compute from the registered operands. The next edge loads the result and flags and moves to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_result, rsp_zero, rsp_carry and rsp_id are stable until the handshake.
  - On the edge where rsp_ready is 1, state → IDLE.
- Opcodes (unsigned arithmetic, W-bit wrap):
  - 000 ADD: result = a+b; carry = bit W of the (W+1)-bit sum.
  - 001 SUB: result = a−b; carry = 1 iff a ≥ b unsigned (no borrow).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 SLT: result = 1 if a < b signed, else 0; carry = 0.
  - 110 SLL: result = a << b[log2(W)−1:0]; carry = 0.
  - 111 SRL: result = a >> b[log2(W)−1:0] (logical); carry = 0.
- rsp_zero is computed on the final result for every opcode.
- Inputs are sampled only on the accept edge. Changes to a requester's valid, op or operands at other times have no effect.
- A requester that drops valid before being granted loses nothing, and `last` is unchanged.

## Timing
- Reset values (asynchronous):
  - state = IDLE.
  - last = 1, so requester 0 wins the first tie.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0, rsp_carry = 0.
  - Operand and op registers = 0.
  - req0_ready and req1_ready follow IDLE arbitration as soon as rst is low.
- Latency: accept at edge t. EXEC during cycle t→t+1. rsp_valid is high from edge t+1.
- If rsp_ready is already high, the handshake completes at edge t+2, IDLE is reached after t+2, and the next accept can occur at edge t+3. Minimum issue interval is 3 cycles.
- Response back-pressure: RESP holds indefinitely. Both readys stay low, so requests wait.
- Simultaneous events:
  - A request arriving in the same cycle as the RESP handshake is not accepted that cycle.
  - Arbitration happens in the following IDLE cycle.
- Reset mid-operation (EXEC or RESP): the operation is discarded and no response is produced. rsp_valid drops asynchronously with rst.

## Test plan
- Reset then single request: req0 ADD a=0xFFFFFFFF, b=1, rsp_ready=1.
  - req0_ready=1 in the first IDLE cycle.
  - rsp_valid=1 at edge accept+1 with rsp_id=0, rsp_result=0, rsp_zero=1, rsp_carry=1.
  - IDLE again after accept+2.
- Opcode sweep, a=0x80000004, b=0x00000002, one op at a time:
  - SUB → 0x80000002, carry 1
  - AND → 0x00000000, zero 1
  - OR → 0x80000006
  - XOR → 0x80000006
  - SLT → 1 (negative < 2)
  - SLL → 0x00000010
  - SRL → 0x20000001
- Round-robin: req0_valid and req1_valid both held high for 4 operations with rsp_ready=1 → grant order 0,1,0,1, and rsp_id matches each.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP with req1_valid=1 → rsp outputs stable, req1_ready=0 throughout. Raising rsp_ready completes the handshake, then req1 is accepted in the next IDLE cycle.
- Reset mid-op: assert rst during EXEC of req1 SUB → rsp_valid stays 0 and all outputs are 0. After release, a simultaneous req0/req1 is granted to req0.
- Operand change after accept: req0 ADD 3+4 accepted, then req0_a driven to 100 during EXEC → rsp_result=7.
